// File: rtl/pmem_port_arbiter_pkg.sv
// Shared types and constants for the program-memory data-port arbiter.
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CPU_LAST   = 2'd1,
    LDR_LAST   = 2'd2,
    LDR_LOCKED = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/pmem_port_arbiter_if.sv
// Requester and memory-side signals of the program-memory data-port arbiter.
interface pmem_port_arbiter_if;
  logic        cpu_req, cpu_we;
  logic [31:2] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;

  logic        ldr_req, ldr_we, ldr_lock;
  logic [31:2] ldr_addr;
  logic [31:0] ldr_wdata;
  logic [3:0]  ldr_be;
  logic        ldr_gnt, ldr_rvalid, ldr_err;
  logic [31:0] ldr_rdata;

  logic        mem_ren, mem_wen;
  logic [31:2] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata, ldr_be,
    output ldr_gnt, ldr_rvalid, ldr_rdata, ldr_err,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata, ldr_be,
    input  ldr_gnt, ldr_rvalid, ldr_rdata, ldr_err,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/pmem_port_arbiter_return.sv
// Read-return path: owner tag, rvalid/rdata/err demux, out-of-range flag.
// Error outputs are live only when PMEM_ARB_RANGE_CHECK_EN is defined.
module pmem_arb_return
  import pmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_gnt,
  input  logic        ldr_gnt,
  input  logic        rd,
  input  logic        oor,
  input  logic [31:0] mem_rdata,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        ldr_rvalid,
  output logic [31:0] ldr_rdata,
  output logic        ldr_err
);
  owner_t      tag_q;
  logic        rd_q, oor_q;
  logic [31:0] cpu_hold_q, ldr_hold_q, ret_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q      <= OWN_NONE;
      rd_q       <= 1'b0;
      oor_q      <= 1'b0;
      cpu_hold_q <= '0;
      ldr_hold_q <= '0;
    end else begin
      tag_q      <= cpu_gnt ? OWN_CPU : (ldr_gnt ? OWN_LDR : OWN_NONE);
      rd_q       <= rd;
      oor_q      <= oor;
      cpu_hold_q <= cpu_rdata;
      ldr_hold_q <= ldr_rdata;
    end
  end

  // rdata is transparent to the memory in the return cycle, then holds.
  always_comb begin
    ret_data   = oor_q ? OOR_RDATA : mem_rdata;
    cpu_rvalid = rd_q && (tag_q == OWN_CPU);
    ldr_rvalid = rd_q && (tag_q == OWN_LDR);
    cpu_rdata  = cpu_rvalid ? ret_data : cpu_hold_q;
    ldr_rdata  = ldr_rvalid ? ret_data : ldr_hold_q;
`ifdef PMEM_ARB_RANGE_CHECK_EN
    cpu_err    = oor_q && (tag_q == OWN_CPU);
    ldr_err    = oor_q && (tag_q == OWN_LDR);
`else
    cpu_err    = 1'b0;
    ldr_err    = 1'b0;
`endif
  end
endmodule

// File: rtl/pmem_port_arbiter.sv
// CPU / loader arbiter for the program-memory data port with starvation guard.
// Optional range check enabled by PMEM_ARB_RANGE_CHECK_EN.
module pmem_port_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned NUM_BRAMS      = 4,
  parameter int unsigned WORDS_PER_BRAM = 2048,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic               clk,
  input  logic               reset,
  pmem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
`ifdef PMEM_ARB_RANGE_CHECK_EN
  localparam logic [29:0] TOTAL_WORDS = 30'(NUM_BRAMS * WORDS_PER_BRAM);
`endif

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             cpu_g, ldr_g, gnt, we, oor, rd;
  logic [31:2]      addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    cpu_g      = 1'b0;
    ldr_g      = 1'b0;
    state_nxt  = state;
    starve_nxt = '0;
    if (state == LDR_LOCKED) begin
      ldr_g     = bus.ldr_req;
      state_nxt = bus.ldr_lock ? LDR_LOCKED : LDR_LAST;
    end else begin
      if (bus.cpu_req && bus.ldr_req) begin
        ldr_g = (starve_cnt == CNT_W'(STARVE_LIMIT));
        cpu_g = !ldr_g;
      end else begin
        cpu_g = bus.cpu_req;
        ldr_g = bus.ldr_req;
      end
      if (ldr_g)      state_nxt = bus.ldr_lock ? LDR_LOCKED : LDR_LAST;
      else if (cpu_g) state_nxt = CPU_LAST;
      if (bus.ldr_req && !ldr_g)
        starve_nxt = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  // With no grant the CPU side still drives address/data onto the port.
  always_comb begin
    gnt           = cpu_g || ldr_g;
    we            = ldr_g ? bus.ldr_we : bus.cpu_we;
    addr          = ldr_g ? bus.ldr_addr : bus.cpu_addr;
`ifdef PMEM_ARB_RANGE_CHECK_EN
    oor           = gnt && (addr >= TOTAL_WORDS);
`else
    oor           = 1'b0;
`endif
    rd            = gnt && !we;
    bus.cpu_gnt   = cpu_g;
    bus.ldr_gnt   = ldr_g;
    bus.mem_addr  = addr;
    bus.mem_wdata = ldr_g ? bus.ldr_wdata : bus.cpu_wdata;
    bus.mem_be    = ldr_g ? bus.ldr_be : bus.cpu_be;
    bus.mem_ren   = rd && !oor;
    bus.mem_wen   = gnt && we && !oor;
  end

  pmem_arb_return u_return (
    .clk        (clk),
    .reset      (reset),
    .cpu_gnt    (cpu_g),
    .ldr_gnt    (ldr_g),
    .rd         (rd),
    .oor        (oor),
    .mem_rdata  (bus.mem_rdata),
    .cpu_rvalid (bus.cpu_rvalid),
    .cpu_rdata  (bus.cpu_rdata),
    .cpu_err    (bus.cpu_err),
    .ldr_rvalid (bus.ldr_rvalid),
    .ldr_rdata  (bus.ldr_rdata),
    .ldr_err    (bus.ldr_err)
  );
endmodule
